qduc_retune_ctrl: RTL and testbench



---
 rtl/qduc_retune_ctrl_pkg.sv | 30 +++
 rtl/qduc_retune_ctrl_gain_mult.sv | 34 +++
 rtl/qduc_retune_ctrl.sv | 151 +++++++++++++++
 tb/tb_qduc_retune_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qduc_retune_ctrl_pkg.sv
// Shared constants, register map and types for the up-converter retune sequencer.
package qduc_pkg;

    localparam int ISZ        = 16;   // sample word size
    localparam int FSZ        = 26;   // NCO tuning word size
    localparam int DIV_BITS   = 8;    // one sample tick every 2^DIV_BITS clocks
    localparam int GW         = 9;    // gain width, 0..GAIN_FS
    localparam int GAIN_FS    = 256;  // unity gain
    localparam int GAIN_SHIFT = 8;    // log2(GAIN_FS)

    localparam logic [1:0] ADDR_FREQ   = 2'd0;
    localparam logic [1:0] ADDR_FLAGS  = 2'd1;
    localparam logic [1:0] ADDR_COMMIT = 2'd2;

    typedef enum logic [2:0] {
        RUN,
        RAMP_DOWN,
        SWITCH,
        SETTLE,
        RAMP_UP
    } state_t;

    // Bit order matches the host flags register: {tuner_byp, iq_swap, lo_ns_en}.
    typedef struct packed {
        logic tuner_byp;
        logic iq_swap;
        logic lo_ns_en;
    } flags_t;

endpackage

// File: rtl/qduc_retune_ctrl_gain_mult.sv
// Registered signed-sample x unsigned-gain multiply, scaled back by GAIN_FS.
// Loads on each enabled edge; an invalid sample loads zero.
module qduc_gain_mult
    import qduc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  valid,
    input  logic signed [ISZ-1:0] s,
    input  logic        [GW-1:0]  gain,
    output logic signed [ISZ-1:0] y
);

    localparam int PW = ISZ + GW + 1;

    logic signed [PW-1:0] prod;

    // Zero-extend the gain so the multiply stays signed; |s*gain| <= 2^23 fits easily.
    always_comb begin
        prod = PW'(s) * PW'($signed({1'b0, gain}));
    end

    // Capture the scaled sample on the tick; the arithmetic shift floors toward -inf.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            y <= '0;
        end else if (en) begin
            y <= valid ? ISZ'(prod >>> GAIN_SHIFT) : '0;
        end
    end

endmodule

// File: rtl/qduc_retune_ctrl.sv
// Retune sequencer in front of the quadrature up-converter: paces the sample
// stream, holds shadow tuning registers and applies them through a
// ramp-down / switch / settle / ramp-up sequence so the LO never jumps under signal.
module qduc_retune_ctrl
    import qduc_pkg::*;
#(
    parameter int RAMP_STEP    = 16,
    parameter int SETTLE_TICKS = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [ISZ-1:0] s_i,
    input  logic signed [ISZ-1:0] s_q,
    output logic signed [ISZ-1:0] out_i,
    output logic signed [ISZ-1:0] out_q,
    output logic [FSZ-1:0]        lo_freq,
    output logic                  lo_ns_en,
    output logic                  iq_swap,
    output logic                  tuner_byp,
    output logic                  busy,
    output logic [15:0]           underrun_cnt
);

    localparam int             SW     = $clog2(SETTLE_TICKS + 1);
    localparam logic [GW:0]    STEP_W = (GW + 1)'(RAMP_STEP);
    localparam logic [GW-1:0]  STEP_G = GW'(RAMP_STEP);
    localparam logic [GW-1:0]  FULL_G = GW'(GAIN_FS);

    logic [DIV_BITS-1:0] cnt;
    logic                tick;
    state_t              state;
    logic [GW-1:0]       gain;
    logic [GW:0]         gain_sum;
    logic [GW-1:0]       gain_up;
    logic [GW-1:0]       gain_dn;
    logic [SW-1:0]       settle_cnt;
    logic [FSZ-1:0]      sh_freq;
    flags_t              sh_flags;
    flags_t              flags;
    logic                pending;
    logic                commit;
    logic                unused_wr_bits;

    assign tick           = &cnt;
    assign s_ready        = tick;
    assign commit         = wr_en && (wr_addr == ADDR_COMMIT);
    assign busy           = (state != RUN) || pending;
    assign lo_ns_en       = flags.lo_ns_en;
    assign iq_swap        = flags.iq_swap;
    assign tuner_byp      = flags.tuner_byp;
    assign unused_wr_bits = &{1'b0, wr_data[31:FSZ]};

    // Free-running period divider, kept in lockstep with the up-converter's divider.
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + 1'b1;
    end

    // Saturating gain steps for the ramps.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
        gain_sum = {1'b0, gain} + STEP_W;
        gain_up  = (gain_sum >= {1'b0, FULL_G}) ? FULL_G : gain_sum[GW-1:0];
        gain_dn  = (gain > STEP_G) ? (gain - STEP_G) : '0;
    end

    // Host shadow registers and the commit request; a same-cycle commit beats the SWITCH clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_freq  <= '0;
            sh_flags <= '0;
            pending  <= 1'b0;
        end else begin
            if (wr_en && (wr_addr == ADDR_FREQ))  sh_freq  <= wr_data[FSZ-1:0];
            if (wr_en && (wr_addr == ADDR_FLAGS)) sh_flags <= flags_t'(wr_data[2:0]);
            if (commit)                pending <= 1'b1;
            else if (state == SWITCH)  pending <= 1'b0;
        end
    end

    // Retune sequencer: tick-paced ramps around a single-clock switch of the active config.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RAMP_UP;
            gain       <= '0;
            settle_cnt <= '0;
            lo_freq    <= '0;
            flags      <= '0;
        end else begin
            case (state)
                RAMP_UP: if (tick) begin
                    if (gain == FULL_G) state <= RUN;
                    else                gain  <= gain_up;
                end
                RUN: if (tick && pending) begin
                    state <= RAMP_DOWN;
                end
                RAMP_DOWN: if (tick) begin
                    if (gain == '0) state <= SWITCH;
                    else            gain  <= gain_dn;
                end
                SWITCH: begin
                    lo_freq    <= sh_freq;
                    flags      <= sh_flags;
                    settle_cnt <= SW'(SETTLE_TICKS);
                    state      <= SETTLE;
                end
                SETTLE: if (tick) begin
                    settle_cnt <= settle_cnt - SW'(1);
                    if (settle_cnt <= SW'(1)) state <= RAMP_UP;
                end
                default: state <= RAMP_UP;
            endcase
        end
    end

    // Count ticks where the stream had nothing to give, holding at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (tick && !s_valid && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    qduc_gain_mult u_mult_i (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .valid (s_valid),
        .s     (s_i),
        .gain  (gain),
        .y     (out_i)
    );

    qduc_gain_mult u_mult_q (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .valid (s_valid),
        .s     (s_q),
        .gain  (gain),
        .y     (out_q)
    );

endmodule

// File: tb/tb_qduc_retune_ctrl.sv
// Directed bench for qduc_retune_ctrl with hand-computed expectations.
// Sample I = 0x4000, Q = 0xE000 (-8192): at gain g, I = 64*g, Q = -32*g.
module tb_qduc_retune_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_i;
    logic [15:0] s_q;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic [25:0] lo_freq;
    logic        lo_ns_en;
    logic        iq_swap;
    logic        tuner_byp;
    logic        busy;
    logic [15:0] underrun_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    qduc_retune_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .out_i        (out_i),
        .out_q        (out_q),
        .lo_freq      (lo_freq),
        .lo_ns_en     (lo_ns_en),
        .iq_swap      (iq_swap),
        .tuner_byp    (tuner_byp),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next tick edge, then sample 1 time unit after it.
    task automatic wait_tick();
        int n = 0;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check("tick_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic host_write(input logic [1:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Cycles from reset release until s_ready, which must be 255.
    task automatic check_first_tick(input string tag);
        int n = 0;
        while (!s_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(n), 32'd255);
    endtask

    // One retune sequence, starting in RUN with a commit already pending.
    task automatic retune_seq(input logic [25:0] old_f, input logic [25:0] new_f,
                              input logic [2:0] old_fl, input logic [2:0] new_fl,
                              input bit settle_commit, input bit busy_end);
        wait_tick();                                   // T0: still full gain
        check("t0_out_i", 32'(out_i), 32'h4000);
        check("t0_busy", 32'(busy), 32'd1);
        wait_ticks(2);                                 // T2: gain 240
        check("rd_out_i", 32'(out_i), 32'h3C00);
        check("rd_out_q", 32'(out_q), 32'hE200);
        wait_ticks(14);                                // T16: gain 16
        check("rd_last_i", 32'(out_i), 32'h0400);
        check("rd_last_freq", 32'(lo_freq), 32'(old_f));
        wait_tick();                                   // T17: gain 0, muted
        check("mute_out_i", 32'(out_i), 32'h0);
        check("mute_out_q", 32'(out_q), 32'h0);
        check("pre_sw_freq", 32'(lo_freq), 32'(old_f));
        check("pre_sw_flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'(old_fl));
        @(posedge clk); #1;                            // SWITCH clock
        check("sw_freq", 32'(lo_freq), 32'(new_f));
        check("sw_flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'(new_fl));
        wait_tick();                                   // S1
        check("settle1_out_i", 32'(out_i), 32'h0);
        wait_ticks(2);                                 // S3
        if (settle_commit) begin
            host_write(2'd0, 32'h000A_BCDE);
            host_write(2'd1, 32'h0000_0001);
            host_write(2'd2, 32'h0);
        end
        wait_ticks(5);                                 // S8
        check("settle8_out_i", 32'(out_i), 32'h0);
        check("settle8_busy", 32'(busy), 32'd1);
        wait_tick();                                   // R1: gain 0 used
        check("ru1_out_i", 32'(out_i), 32'h0);
        wait_tick();                                   // R2: gain 16
        check("ru2_out_i", 32'(out_i), 32'h0400);
        wait_ticks(14);                                // R16: gain 240
        check("ru16_busy", 32'(busy), 32'd1);
        wait_tick();                                   // R17: full gain, RUN
        check("ru17_out_i", 32'(out_i), 32'h4000);
        check("ru17_out_q", 32'(out_q), 32'hE000);
        check("ru17_busy", 32'(busy), 32'(busy_end));
        check("ru17_freq", 32'(lo_freq), 32'(new_f));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 32'h0;
        s_valid = 1'b1;
        s_i     = 16'h4000;
        s_q     = 16'hE000;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_i", 32'(out_i), 32'h0);
        check("rst_out_q", 32'(out_q), 32'h0);
        check("rst_freq", 32'(lo_freq), 32'h0);
        check("rst_flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'h0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_underrun", 32'(underrun_cnt), 32'h0);
        check("rst_ready", 32'(s_ready), 32'd0);

        // Soft start from mute
        reset = 1'b0;
        check_first_tick("first_tick_delay");
        @(posedge clk); #1;                            // tick 1: gain 0
        check("up1_out_i", 32'(out_i), 32'h0);
        wait_tick();                                   // tick 2: gain 16
        check("up2_out_i", 32'(out_i), 32'h0400);
        check("up2_out_q", 32'(out_q), 32'hFE00);
        wait_ticks(7);                                 // tick 9: gain 128
        check("up9_out_i", 32'(out_i), 32'h2000);
        check("up9_out_q", 32'(out_q), 32'hF000);
        wait_ticks(7);                                 // tick 16: gain 240
        check("up16_out_i", 32'(out_i), 32'h3C00);
        check("up16_busy", 32'(busy), 32'd1);
        wait_tick();                                   // tick 17: gain 256
        check("up17_out_i", 32'(out_i), 32'h4000);
        check("up17_out_q", 32'(out_q), 32'hE000);
        check("up17_busy", 32'(busy), 32'd0);

        // Unity gain is exact at both extremes
        s_i = 16'h7FFF;
        s_q = 16'h8000;
        wait_tick();
        check("pass_max_i", 32'(out_i), 32'h7FFF);
        check("pass_min_q", 32'(out_q), 32'h8000);
        s_i = 16'h4000;
        s_q = 16'hE000;

        // Shadow writes alone never reach the active outputs
        host_write(2'd0, 32'h0012_3456);
        host_write(2'd1, 32'h0000_0005);
        host_write(2'd3, 32'hFFFF_FFFF);
        wait_ticks(2);
        check("shadow_freq", 32'(lo_freq), 32'h0);
        check("shadow_flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'h0);
        check("shadow_busy", 32'(busy), 32'd0);

        // Underruns
        s_valid = 1'b0;
        wait_tick();
        check("ur1_out_i", 32'(out_i), 32'h0);
        check("ur1_cnt", 32'(underrun_cnt), 32'd1);
        wait_ticks(2);
        check("ur3_out_q", 32'(out_q), 32'h0);
        check("ur3_cnt", 32'(underrun_cnt), 32'd3);
        s_valid = 1'b1;
        wait_tick();
        check("ur_recover_i", 32'(out_i), 32'h4000);
        check("ur_hold_cnt", 32'(underrun_cnt), 32'd3);

        // First retune
        host_write(2'd2, 32'h0);
        check("commit_busy", 32'(busy), 32'd1);
        retune_seq(26'h0, 26'h12_3456, 3'b000, 3'b101, 1'b0, 1'b0);

        // Second retune with another commit landing in SETTLE, then the follow-on sequence
        host_write(2'd0, 32'h0011_1111);
        host_write(2'd1, 32'h0000_0002);
        host_write(2'd2, 32'h0);
        retune_seq(26'h12_3456, 26'h11_1111, 3'b101, 3'b010, 1'b1, 1'b1);
        retune_seq(26'h11_1111, 26'h0A_BCDE, 3'b010, 3'b001, 1'b0, 1'b0);

        // Reset in the middle of RAMP_DOWN
        host_write(2'd2, 32'h0);
        wait_tick();                                   // T0
        wait_ticks(4);                                 // T4: gain 208
        check("abort_pre_i", 32'(out_i), 32'h3400);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_out_i", 32'(out_i), 32'h0);
        check("abort_out_q", 32'(out_q), 32'h0);
        check("abort_freq", 32'(lo_freq), 32'h0);
        check("abort_flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'h0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_underrun", 32'(underrun_cnt), 32'h0);
        reset = 1'b0;
        check_first_tick("abort_tick_delay");
        @(posedge clk); #1;                            // tick 1 after restart: gain 0
        check("abort_up1_i", 32'(out_i), 32'h0);
        wait_ticks(16);                                // tick 17: back in RUN, no stale commit
        check("abort_up17_i", 32'(out_i), 32'h4000);
        check("abort_up17_busy", 32'(busy), 32'd0);
        check("abort_up17_freq", 32'(lo_freq), 32'h0);

        // Underrun counter saturation
        force dut.underrun_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.underrun_cnt;
        s_valid = 1'b0;
        wait_tick();
        check("sat_reach", 32'(underrun_cnt), 32'hFFFF);
        wait_tick();
        check("sat_hold", 32'(underrun_cnt), 32'hFFFF);
        s_valid = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
